// File: rtl/board_ctrl.sv
// board_ctrl: game-state controller for a 3x3 tic-tac-toe board.
//
// Validates square clicks against the internal board, alternates players,
// detects wins and draws, and drives the nine per-square draw stages. The
// displayed copy of the board is reloaded only on the rising edge of
// vertical blank, so the overlay never changes mid-frame.
//
// Optional feature macro: WIN_HIGHLIGHT_EN
//   defined   -> the winning line is latched and its squares show WIN_COLOR
//   undefined -> every occupied square shows its owner's colour
//
// Ports:
//   pclk          pixel clock
//   rst           synchronous active-high reset
//   start_en      game screen active
//   choice_en     player-choice menu active (board frozen)
//   first_player  player that starts a new game (0=X, 1=O)
//   new_game      one-cycle pulse: clear the board and restart
//   click         one-cycle pulse: a square was selected
//   click_idx     selected square 1..9, row-major from top-left
//   vblnk_in      vertical blank from the timing chain
//   square_en     bit i set = square i+1 is drawn (displayed copy)
//   square_color  colour of square i+1 at [12*i+11:12*i] (displayed copy)
//   turn          player to move (0=X, 1=O)
//   game_over     win or draw reached
//   winner        00 none, 01 X, 10 O, 11 draw
//   invalid_move  one-cycle pulse on a rejected click
module board_ctrl #(
  parameter logic [11:0] X_COLOR   = 12'hF00,
  parameter logic [11:0] O_COLOR   = 12'h00F,
  parameter logic [11:0] WIN_COLOR = 12'h0F0
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         start_en,
  input  logic         choice_en,
  input  logic         first_player,
  input  logic         new_game,
  input  logic         click,
  input  logic [3:0]   click_idx,
  input  logic         vblnk_in,
  output logic [8:0]   square_en,
  output logic [107:0] square_color,
  output logic         turn,
  output logic         game_over,
  output logic [1:0]   winner,
  output logic         invalid_move
);

  typedef enum logic [1:0] {IDLE, WAIT_CLICK, CHECK, OVER} state_t;

  state_t       state;
  logic [8:0]   occ;       // square occupied
  logic [8:0]   owner;     // 0=X, 1=O (meaningful only where occ is set)
  logic [3:0]   move_cnt;
  logic         vblnk_d;
`ifdef WIN_HIGHLIGHT_EN
  logic [2:0]   win_line;
`endif

  // Bit mask of the three squares forming line li.
  function automatic logic [8:0] line_mask(input logic [2:0] li);
    case (li)
      3'd0:    line_mask = 9'h007;  // row 1-2-3
      3'd1:    line_mask = 9'h038;  // row 4-5-6
      3'd2:    line_mask = 9'h1C0;  // row 7-8-9
      3'd3:    line_mask = 9'h049;  // col 1-4-7
      3'd4:    line_mask = 9'h092;  // col 2-5-8
      3'd5:    line_mask = 9'h124;  // col 3-6-9
      3'd6:    line_mask = 9'h111;  // diag 1-5-9
      default: line_mask = 9'h054;  // diag 3-5-7
    endcase
  endfunction

  logic       active;
  logic       idx_ok;
  logic [3:0] idx_m1;
  logic [8:0] sel;
  logic       square_free;
  logic       commit;

  assign active      = start_en && !choice_en;
  assign idx_ok      = (click_idx >= 4'd1) && (click_idx <= 4'd9);
  assign idx_m1      = click_idx - 4'd1;
  assign sel         = idx_ok ? (9'd1 << idx_m1) : 9'd0;
  assign square_free = idx_ok && ((occ & sel) == 9'd0);
  assign commit      = vblnk_in && !vblnk_d;

  // Line evaluation for the player who just moved (turn has not toggled yet).
  // Scanning from the highest index down leaves the lowest completed line.
  logic       win_found;
  logic [8:0] mover_bits;
  logic [8:0] cur_mask;
`ifdef WIN_HIGHLIGHT_EN
  logic [2:0] win_idx;
`endif

  always_comb begin
    win_found  = 1'b0;
    cur_mask   = 9'd0;
    mover_bits = occ & (turn ? owner : ~owner);
`ifdef WIN_HIGHLIGHT_EN
    win_idx    = 3'd0;
`endif
    for (int li = 7; li >= 0; li--) begin
      cur_mask = line_mask(3'(li));
      if ((mover_bits & cur_mask) == cur_mask) begin
        win_found = 1'b1;
`ifdef WIN_HIGHLIGHT_EN
        win_idx   = 3'(li);
`endif
      end
    end
  end

  // Squares that should be drawn in the highlight colour.
  logic [8:0] hl_mask;
`ifdef WIN_HIGHLIGHT_EN
  assign hl_mask = (winner == 2'b01 || winner == 2'b10) ? line_mask(win_line) : 9'd0;
`else
  assign hl_mask = 9'd0;
`endif

  logic [107:0] color_next;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_color
      assign color_next[12*gi +: 12] = !occ[gi]     ? 12'h000   :
                                       hl_mask[gi]  ? WIN_COLOR :
                                       owner[gi]    ? O_COLOR   : X_COLOR;
    end
  endgenerate

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= IDLE;
      occ          <= 9'd0;
      owner        <= 9'd0;
      move_cnt     <= 4'd0;
      vblnk_d      <= 1'b0;
      square_en    <= 9'd0;
      square_color <= 108'd0;
      turn         <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      invalid_move <= 1'b0;
`ifdef WIN_HIGHLIGHT_EN
      win_line     <= 3'd0;
`endif
    end else begin
      vblnk_d      <= vblnk_in;
      invalid_move <= 1'b0;

      // The display samples the board before any write in this same cycle.
      if (commit) begin
        square_en    <= occ;
        square_color <= color_next;
      end

      if (!start_en) begin
        state     <= IDLE;
        occ       <= 9'd0;
        owner     <= 9'd0;
        move_cnt  <= 4'd0;
        game_over <= 1'b0;
        winner    <= 2'b00;
      end else if (new_game && state != IDLE) begin
        state     <= WAIT_CLICK;
        occ       <= 9'd0;
        owner     <= 9'd0;
        move_cnt  <= 4'd0;
        game_over <= 1'b0;
        winner    <= 2'b00;
        turn      <= first_player;
      end else begin
        case (state)
          IDLE: begin
            if (active) begin
              state     <= WAIT_CLICK;
              occ       <= 9'd0;
              owner     <= 9'd0;
              move_cnt  <= 4'd0;
              game_over <= 1'b0;
              winner    <= 2'b00;
              turn      <= first_player;
            end
          end
          WAIT_CLICK: begin
            if (active && click) begin
              if (square_free) begin
                occ      <= occ | sel;
                owner    <= turn ? (owner | sel) : (owner & ~sel);
                move_cnt <= move_cnt + 4'd1;
                state    <= CHECK;
              end else begin
                invalid_move <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (win_found) begin
              winner    <= turn ? 2'b10 : 2'b01;
              game_over <= 1'b1;
              state     <= OVER;
`ifdef WIN_HIGHLIGHT_EN
              win_line  <= win_idx;
`endif
            end else if (move_cnt == 4'd9) begin
              winner    <= 2'b11;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              turn  <= ~turn;
              state <= WAIT_CLICK;
            end
          end
          default: begin
            // OVER: held until new_game or start_en drops
            state <= OVER;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: self-checking bench for board_ctrl.
// Directed table of clicks, hand-written multi-cycle sequences, then random
// transactions checked against a square-array game model.
module tb_board_ctrl;

  logic         pclk = 1'b0;
  logic         rst;
  logic         start_en;
  logic         choice_en;
  logic         first_player;
  logic         new_game;
  logic         click;
  logic [3:0]   click_idx;
  logic         vblnk_in;
  logic [8:0]   square_en;
  logic [107:0] square_color;
  logic         turn;
  logic         game_over;
  logic [1:0]   winner;
  logic         invalid_move;

  localparam logic [11:0] XC = 12'hF00;
  localparam logic [11:0] OC = 12'h00F;
  localparam logic [11:0] WC = 12'h0F0;

  board_ctrl dut (
    .pclk(pclk), .rst(rst), .start_en(start_en), .choice_en(choice_en),
    .first_player(first_player), .new_game(new_game), .click(click),
    .click_idx(click_idx), .vblnk_in(vblnk_in), .square_en(square_en),
    .square_color(square_color), .turn(turn), .game_over(game_over),
    .winner(winner), .invalid_move(invalid_move)
  );

  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [107:0] a, input logic [107:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, a, e);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // Click, check the invalid pulse on the next cycle and that it ends after one cycle.
  task automatic apply_click(input int idx, input bit exp_inv);
    click     = 1'b1;
    click_idx = 4'(idx);
    tick;
    chk("invalid_pulse", 108'(invalid_move), 108'(exp_inv));
    click = 1'b0;
    tick;
    chk("invalid_end", 108'(invalid_move), 108'd0);
  endtask

  task automatic strobe;
    vblnk_in = 1'b1;
    tick;
    vblnk_in = 1'b0;
    tick;
  endtask

  task automatic pulse_new_game(input bit fp);
    first_player = fp;
    new_game     = 1'b1;
    tick;
    new_game     = 1'b0;
  endtask

  // ---------------- reference model: plain square array ----------------
  int L [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                   '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int       mb [9];      // 0 empty, 1 X, 2 O
  int       mturn;       // 0 X, 1 O
  int       mcnt;
  bit       mover;
  logic [1:0] mwin;
  int       mline;

  task automatic model_start(input bit fp);
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mturn = fp; mcnt = 0; mover = 0; mwin = 2'b00; mline = -1;
  endtask

  task automatic model_click(input int idx, output bit inv);
    inv = 0;
    if (mover) return;
    if (idx < 1 || idx > 9 || mb[idx-1] != 0) begin
      inv = 1;
      return;
    end
    mb[idx-1] = mturn + 1;
    mcnt++;
    mline = -1;
    for (int l = 0; l < 8; l++)
      if (mline < 0 && mb[L[l][0]] == mturn + 1 && mb[L[l][1]] == mturn + 1 &&
          mb[L[l][2]] == mturn + 1)
        mline = l;
    if (mline >= 0) begin
      mover = 1;
      mwin  = (mturn == 0) ? 2'b01 : 2'b10;
    end else if (mcnt == 9) begin
      mover = 1;
      mwin  = 2'b11;
    end else begin
      mturn = 1 - mturn;
    end
  endtask

  task automatic model_disp(output logic [8:0] en, output logic [107:0] col);
    logic [11:0] c;
    en  = '0;
    col = '0;
    for (int i = 0; i < 9; i++) begin
      if (mb[i] != 0) begin
        en[i] = 1'b1;
        c = (mb[i] == 1) ? XC : OC;
`ifdef WIN_HIGHLIGHT_EN
        if ((mwin == 2'b01 || mwin == 2'b10) &&
            (L[mline][0] == i || L[mline][1] == i || L[mline][2] == i))
          c = WC;
`endif
        col[12*i +: 12] = c;
      end
    end
  endtask

  // ---------------- directed click table ----------------
  typedef struct {
    int         idx;
    bit         inv;
    bit         trn;
    bit         ovr;
    logic [1:0] win;
  } vec_t;

  vec_t vt [10];
  int   draw_seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};

  logic [8:0]   e_en;
  logic [107:0] e_col;
  bit           e_inv;

  initial begin
    vt[0] = '{1,  0, 1, 0, 2'b00};
    vt[1] = '{1,  1, 1, 0, 2'b00};   // occupied
    vt[2] = '{4,  0, 0, 0, 2'b00};
    vt[3] = '{0,  1, 0, 0, 2'b00};   // index 0
    vt[4] = '{2,  0, 1, 0, 2'b00};
    vt[5] = '{15, 1, 1, 0, 2'b00};   // index above 9
    vt[6] = '{5,  0, 0, 0, 2'b00};
    vt[7] = '{10, 1, 0, 0, 2'b00};
    vt[8] = '{3,  0, 0, 1, 2'b01};   // X completes the top row
    vt[9] = '{7,  0, 0, 1, 2'b01};   // ignored after game over

    rst = 1; start_en = 0; choice_en = 0; first_player = 0; new_game = 0;
    click = 0; click_idx = 0; vblnk_in = 0;
    repeat (3) tick;
    rst = 0;
    tick;
    chk("rst_en", 108'(square_en), 108'd0);
    chk("rst_color", square_color, 108'd0);
    chk("rst_turn", 108'(turn), 108'd0);
    chk("rst_over", 108'(game_over), 108'd0);
    chk("rst_winner", 108'(winner), 108'd0);
    chk("rst_invalid", 108'(invalid_move), 108'd0);

    // first move and display commit
    start_en = 1;
    tick;
    apply_click(5, 0);
    chk("t1_turn", 108'(turn), 108'd1);
    strobe;
    chk("t1_en", 108'(square_en), 108'h010);
    chk("t1_color", square_color, {48'h0, 12'hF00, 48'h0});
    $display("[TB] first move idx 5: en=%h turn=%0d", square_en, turn);

    // rejected clicks
    apply_click(5, 1);
    chk("t2_turn", 108'(turn), 108'd1);
    apply_click(0, 1);
    chk("t2_turn0", 108'(turn), 108'd1);
    strobe;
    chk("t2_en", 108'(square_en), 108'h010);

    // table: X wins the top row, invalid clicks interleaved
    pulse_new_game(0);
    for (int i = 0; i < 10; i++) begin
      apply_click(vt[i].idx, vt[i].inv);
      chk("tbl_turn", 108'(turn), 108'(vt[i].trn));
      chk("tbl_over", 108'(game_over), 108'(vt[i].ovr));
      chk("tbl_winner", 108'(winner), 108'(vt[i].win));
      $display("[TB] table %0d: idx=%0d inv=%0d turn=%0d over=%0d winner=%b",
               i, vt[i].idx, vt[i].inv, turn, game_over, winner);
    end
    strobe;
    chk("win_en", 108'(square_en), 108'h01F);
`ifdef WIN_HIGHLIGHT_EN
    chk("win_color", square_color, {48'h0, OC, OC, WC, WC, WC});
`else
    chk("win_color", square_color, {48'h0, OC, OC, XC, XC, XC});
`endif

    // full board, no line
    pulse_new_game(0);
    for (int i = 0; i < 9; i++) apply_click(draw_seq[i], 0);
    chk("draw_winner", 108'(winner), 108'(2'b11));
    chk("draw_over", 108'(game_over), 108'd1);
    $display("[TB] draw game: winner=%b over=%0d", winner, game_over);

    // click in the same cycle as the commit strobe
    pulse_new_game(0);
    strobe;
    click = 1; click_idx = 4'd5; vblnk_in = 1;
    tick;
    click = 0; vblnk_in = 0;
    chk("coinc_pre", 108'(square_en), 108'd0);
    tick;
    strobe;
    chk("coinc_post", 108'(square_en), 108'h010);
    $display("[TB] coincident write: en=%h", square_en);

    // new_game beats a simultaneous click
    first_player = 1;
    new_game = 1; click = 1; click_idx = 4'd1;
    tick;
    new_game = 0; click = 0;
    chk("ng_inv", 108'(invalid_move), 108'd0);
    tick;
    chk("ng_turn", 108'(turn), 108'd1);
    strobe;
    chk("ng_en", 108'(square_en), 108'd0);

    // choice menu freezes the board, start_en low clears it
    pulse_new_game(0);
    apply_click(5, 0);
    choice_en = 1;
    apply_click(1, 0);
    strobe;
    chk("choice_en_held", 108'(square_en), 108'h010);
    choice_en = 0;
    start_en  = 0;
    tick;
    strobe;
    chk("idle_en", 108'(square_en), 108'd0);
    chk("idle_color", square_color, 108'd0);
    $display("[TB] choice/idle: en=%h", square_en);

    // randomized transactions against the model
    first_player = 0;
    start_en = 1;
    tick;
    model_start(0);
    for (int t = 0; t < 300; t++) begin
      int kind;
      int idx;
      bit fp;
      kind = $urandom_range(0, 11);
      if (kind == 0) begin
        fp = 1'($urandom_range(0, 1));
        pulse_new_game(fp);
        tick;
        model_start(fp);
        chk("rnd_ng_turn", 108'(turn), 108'(fp));
        $display("[TB] rnd %0d: new_game fp=%0d", t, fp);
      end else if (kind <= 2) begin
        strobe;
        model_disp(e_en, e_col);
        chk("rnd_en", 108'(square_en), 108'(e_en));
        chk("rnd_color", square_color, e_col);
        $display("[TB] rnd %0d: strobe en=%h", t, square_en);
      end else begin
        idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
        model_click(idx, e_inv);
        apply_click(idx, e_inv);
        chk("rnd_turn", 108'(turn), 108'(mturn));
        chk("rnd_over", 108'(game_over), 108'(mover));
        chk("rnd_winner", 108'(winner), 108'(mwin));
        $display("[TB] rnd %0d: click %0d inv=%0d turn=%0d winner=%b", t, idx, e_inv, turn, winner);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
